// File: rtl/generador_letra.sv
// generador_letra: "GRUPO 11" 8x16 text overlay, registered RGB; GEN_LETRA_BG_EN fills the box with ~rgbswitches
module generador_letra #(
  parameter int X0 = 296,
  parameter int Y0 = 232,
  parameter int NCHAR = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       video_on,
  input  logic [2:0] rgbswitches,
  input  logic [9:0] pixelx,
  input  logic [9:0] pixely,
  output logic [2:0] rgbtext
);
  localparam logic [9:0] XL = 10'(X0);
  localparam logic [9:0] XH = 10'(X0 + 8 * NCHAR);
  localparam logic [9:0] YL = 10'(Y0);
  localparam logic [9:0] YH = 10'(Y0 + 16);
  // CP437 glyphs, row 0 in the top byte
  localparam logic [127:0] F_G = 128'h00003C66C2C0C0DEC6C6663A00000000;
  localparam logic [127:0] F_R = 128'h0000FC6666667C6C666666E600000000;
  localparam logic [127:0] F_U = 128'h0000C6C6C6C6C6C6C6C6C67C00000000;
  localparam logic [127:0] F_P = 128'h0000FC6666667C60606060F000000000;
  localparam logic [127:0] F_O = 128'h00007CC6C6C6C6C6C6C6C67C00000000;
  localparam logic [127:0] F_1 = 128'h00001838781818181818187E00000000;
  logic         win;
  logic [5:0]   dx;
  logic [3:0]   r;
  logic [127:0] glyph;
  logic [7:0]   row;
  logic         gbit;
  logic [2:0]   nxt;
  assign win = pixelx >= XL && pixelx < XH && pixely >= YL && pixely < YH;
  assign dx = 6'(pixelx - XL);
  assign r = 4'(pixely - YL);
  assign glyph = (dx[5:3] == 3'd0) ? F_G :
                 (dx[5:3] == 3'd1) ? F_R :
                 (dx[5:3] == 3'd2) ? F_U :
                 (dx[5:3] == 3'd3) ? F_P :
                 (dx[5:3] == 3'd4) ? F_O :
                 (dx[5:3] == 3'd5) ? 128'h0 : F_1;
  assign row = glyph[{~r, 3'b000} +: 8];
  assign gbit = row[~dx[2:0]];
`ifdef GEN_LETRA_BG_EN
  assign nxt = (!video_on || !win) ? 3'b000 : gbit ? rgbswitches : ~rgbswitches;
`else
  assign nxt = (video_on && win && gbit) ? rgbswitches : 3'b000;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) rgbtext <= 3'b000;
    else rgbtext <= nxt;
endmodule

// File: tb/tb_generador_letra.sv
// tb_generador_letra: directed vector table plus reset and latency sequences
module tb_generador_letra;
  logic       clk = 0;
  logic       reset = 1;
  logic       video_on = 0;
  logic [2:0] rgbswitches = 0;
  logic [9:0] pixelx = 0;
  logic [9:0] pixely = 0;
  logic [2:0] rgbtext;
  int pass = 0;
  int total = 0;
`ifdef GEN_LETRA_BG_EN
  localparam bit BG = 1;
`else
  localparam bit BG = 0;
`endif
  typedef struct {
    logic       vo;
    logic [2:0] sw;
    logic [9:0] px;
    logic [9:0] py;
    logic [2:0] exp;
    string      nm;
  } vec_t;
  vec_t v[$];
  generador_letra dut (
    .clk(clk), .reset(reset), .video_on(video_on), .rgbswitches(rgbswitches),
    .pixelx(pixelx), .pixely(pixely), .rgbtext(rgbtext)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] miss(input logic [2:0] sw);
    return BG ? ~sw : 3'b000;
  endfunction
  task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%b exp=%b", nm, got, exp);
    else pass++;
  endtask
  task automatic apply(input logic vo, input logic [2:0] sw, input logic [9:0] px, input logic [9:0] py);
    @(negedge clk);
    video_on = vo;
    rgbswitches = sw;
    pixelx = px;
    pixely = py;
    @(posedge clk);
    #1;
  endtask
  initial begin
    v.push_back('{1'b1, 3'b001, 10'd298, 10'd234, 3'b001, "G r2c2 hit"});
    v.push_back('{1'b0, 3'b111, 10'd298, 10'd234, 3'b000, "blank"});
    v.push_back('{1'b1, 3'b111, 10'd295, 10'd234, 3'b000, "left of window"});
    v.push_back('{1'b1, 3'b111, 10'd360, 10'd234, 3'b000, "right of window"});
    v.push_back('{1'b1, 3'b111, 10'd700, 10'd234, 3'b000, "x beyond 639"});
    v.push_back('{1'b1, 3'b111, 10'd298, 10'd500, 3'b000, "y beyond 479"});
    v.push_back('{1'b1, 3'b111, 10'd298, 10'd231, 3'b000, "above window"});
    v.push_back('{1'b1, 3'b111, 10'd298, 10'd248, 3'b000, "below window"});
    v.push_back('{1'b1, 3'b011, 10'd298, 10'd247, miss(3'b011), "G r15 miss"});
    v.push_back('{1'b1, 3'b010, 10'd304, 10'd234, 3'b010, "R r2c0 hit"});
    v.push_back('{1'b1, 3'b010, 10'd310, 10'd234, miss(3'b010), "R r2c6 miss"});
    v.push_back('{1'b1, 3'b100, 10'd312, 10'd237, 3'b100, "U r5c0 hit"});
    v.push_back('{1'b1, 3'b100, 10'd314, 10'd237, miss(3'b100), "U r5c2 miss"});
    v.push_back('{1'b1, 3'b110, 10'd321, 10'd239, 3'b110, "P r7c1 hit"});
    v.push_back('{1'b1, 3'b110, 10'd323, 10'd239, miss(3'b110), "P r7c3 miss"});
    v.push_back('{1'b1, 3'b011, 10'd329, 10'd243, 3'b011, "O r11c1 hit"});
    v.push_back('{1'b1, 3'b101, 10'd354, 10'd235, 3'b101, "1 r3c2 hit"});
    v.push_back('{1'b1, 3'b101, 10'd352, 10'd235, miss(3'b101), "1 r3c0 miss"});
    v.push_back('{1'b1, 3'b111, 10'd298, 10'd239, miss(3'b111), "G r7c2 miss"});
    v.push_back('{1'b1, 3'b111, 10'd299, 10'd239, 3'b111, "G r7c3 hit"});
    v.push_back('{1'b1, 3'b000, 10'd298, 10'd234, 3'b000, "black colour"});
    #1;
    chk("reset state", rgbtext, 3'b000);
    @(negedge clk);
    reset = 0;
    foreach (v[i]) begin
      apply(v[i].vo, v[i].sw, v[i].px, v[i].py);
      chk(v[i].nm, rgbtext, v[i].exp);
    end
    for (int x = 296; x < 360; x++) begin
      apply(1'b1, 3'b111, 10'(x), 10'd232);
      chk($sformatf("row0 x=%0d", x), rgbtext, miss(3'b111));
    end
    for (int x = 336; x < 344; x++)
      for (int y = 232; y < 248; y += 5) begin
        apply(1'b1, 3'b111, 10'(x), 10'(y));
        chk($sformatf("space %0d,%0d", x, y), rgbtext, 3'b000);
      end
    apply(1'b1, 3'b111, 10'd298, 10'd234);
    chk("pre-reset hit", rgbtext, 3'b111);
    #2 reset = 1;
    #1 chk("async reset", rgbtext, 3'b000);
    @(posedge clk);
    #1 chk("reset held", rgbtext, 3'b000);
    @(negedge clk);
    reset = 0;
    #1 chk("reset released pre-edge", rgbtext, 3'b000);
    @(posedge clk);
    #1 chk("post-reset hit", rgbtext, 3'b111);
    apply(1'b1, 3'b001, 10'd298, 10'd234);
    chk("colour 001", rgbtext, 3'b001);
    @(negedge clk);
    rgbswitches = 3'b110;
    #1 chk("colour latency hold", rgbtext, 3'b001);
    @(posedge clk);
    #1 chk("colour 110", rgbtext, 3'b110);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
